// File: rtl/hs_pkg.sv
// Shared constants for the hs_slave receive link: default widths and the
// fixed master stream pattern used by the optional HS_SLAVE_SEQ_CHECK_EN checker.
package hs_pkg;

  localparam int unsigned DEF_DATA_W = 3;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_CNT_W  = 8;

  localparam logic [2:0] PAT0 = 3'b111;
  localparam logic [2:0] PAT1 = 3'b101;
  localparam logic [2:0] PAT2 = 3'b110;

  localparam int unsigned PAT_LEN = 3;

  // Expected beat for a given position in the repeating master stream.
  function automatic logic [2:0] pat_at(input logic [1:0] idx);
    logic [2:0] p;
    case (idx)
      2'd0:    p = PAT0;
      2'd1:    p = PAT1;
      default: p = PAT2;
    endcase
    return p;
  endfunction

  // Next stream position, wrapping after the last pattern entry.
  function automatic logic [1:0] pat_next(input logic [1:0] idx);
    return (32'(idx) == PAT_LEN - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/hs_slave_if.sv
// Valid/ready receive link plus the show-ahead read port and debug status of hs_slave.
interface hs_slave_if #(
  parameter int unsigned DATA_W = hs_pkg::DEF_DATA_W,
  parameter int unsigned DEPTH  = hs_pkg::DEF_DEPTH,
  parameter int unsigned CNT_W  = hs_pkg::DEF_CNT_W
) ();
  import hs_pkg::*;

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              rd_en;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  beat_cnt;
  logic              seq_err;

  modport master (
    output valid, data, rd_en,
    input  ready, rd_valid, rd_data, full, empty, level, beat_cnt, seq_err
  );

  modport slave (
    input  valid, data, rd_en,
    output ready, rd_valid, rd_data, full, empty, level, beat_cnt, seq_err
  );

endinterface

// File: rtl/hs_sync_fifo.sv
// Synchronous show-ahead FIFO: storage, wrapping pointers, level, full/empty.
// A pop while full never frees a slot for a push in the same cycle.
module hs_sync_fifo
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_level == LVL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers rely on DEPTH being a power of two for natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

endmodule

// File: rtl/hs_slave.sv
// Receiving end of the valid/ready link: buffers accepted beats, counts them,
// and (with HS_SLAVE_SEQ_CHECK_EN defined) flags deviations from the master's fixed stream.
module hs_slave
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic      sys_clk,
  input  logic      sys_rst_n,
  hs_slave_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;
  logic [LVL_W-1:0]  w_level;
  logic [CNT_W-1:0]  r_beat_cnt;

  // Ready depends only on registered occupancy, never on valid.
  assign w_push = bus.valid && !w_full;
  assign w_pop  = bus.rd_en && !w_empty;

  hs_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .i_push    (w_push),
    .i_data    (bus.data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_push) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

`ifdef HS_SLAVE_SEQ_CHECK_EN
  logic [1:0] r_pat_idx;
  logic       r_seq_err;

  // Any idle cycle restarts the expected stream; stalled beats keep their position.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pat_idx <= 2'd0;
      r_seq_err <= 1'b0;
    end else if (!bus.valid) begin
      r_pat_idx <= 2'd0;
    end else if (w_push) begin
      if (bus.data != DATA_W'(pat_at(r_pat_idx))) begin
        r_seq_err <= 1'b1;
      end
      r_pat_idx <= pat_next(r_pat_idx);
    end
  end

  assign bus.seq_err = r_seq_err;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.ready    = !w_full;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.rd_valid = !w_empty;
  assign bus.rd_data  = w_rd_data;
  assign bus.level    = w_level;
  assign bus.beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_hs_slave.sv
// Scoreboard bench for hs_slave: a queue-based model predicts FIFO contents and status,
// a negedge monitor compares every cycle.
module tb_hs_slave;
  import hs_pkg::*;

  localparam int unsigned DW = 3;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  hs_slave_if #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) bus ();

  hs_slave #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q[$];
  int            m_cnt;
  bit            m_err;
  int            m_idx;
  bit            m_blocked;
  logic [2:0]    pat [3];
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt     = 0;
    m_err     = 1'b0;
    m_idx     = 0;
    m_blocked = 1'b0;
  endtask

  // Effect of the coming rising edge, computed from the current inputs.
  task automatic model_step();
    int sz;
    bit psh;
    bit pp;
    sz  = m_q.size();
    psh = bus.valid && (sz < DP);
    pp  = bus.rd_en && (sz > 0);
    if (pp) void'(m_q.pop_front());
    if (psh) begin
      m_q.push_back(bus.data);
      m_cnt = (m_cnt + 1) % (1 << CW);
    end
    if (!bus.valid) m_idx = 0;
    else if (psh) begin
`ifdef HS_SLAVE_SEQ_CHECK_EN
      if (bus.data != pat[m_idx]) m_err = 1'b1;
`endif
      m_idx = (m_idx + 1) % 3;
    end
    m_blocked = bus.valid && !psh;
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      chk("level",    32'(bus.level),    32'(m_q.size()));
      chk("empty",    32'(bus.empty),    32'(m_q.size() == 0));
      chk("full",     32'(bus.full),     32'(m_q.size() == DP));
      chk("ready",    32'(bus.ready),    32'(m_q.size() < DP));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(m_q[0]));
      else                chk("rd_data_empty", 32'(bus.rd_data), 32'd0);
      chk("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
      chk("seq_err",  32'(bus.seq_err),  32'(m_err));
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    bus.valid = v;
    bus.data  = d;
    bus.rd_en = r;
    @(negedge sys_clk);
    #1 model_step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"},    32'(bus.ready),    32'd1);
    chk({tag, "_empty"},    32'(bus.empty),    32'd1);
    chk({tag, "_full"},     32'(bus.full),     32'd0);
    chk({tag, "_level"},    32'(bus.level),    32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
    chk({tag, "_beat_cnt"}, 32'(bus.beat_cnt), 32'd0);
    chk({tag, "_seq_err"},  32'(bus.seq_err),  32'd0);
  endtask

  task automatic do_reset();
    bus.valid = 1'b0;
    bus.data  = '0;
    bus.rd_en = 1'b0;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1 reset_checks("rst");
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic          v;
    logic          r;
    logic          exp_err;
    pat[0] = 3'b111;
    pat[1] = 3'b101;
    pat[2] = 3'b110;
    bus.valid = 1'b0;
    bus.data  = '0;
    bus.rd_en = 1'b0;
    #1;
    sys_rst_n = 1'b0;
    model_reset();
    #1 mon_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 reset_checks("init");
    sys_rst_n = 1'b1;

    // Streaming without backpressure: occupancy stays at one.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, pat[k], 1'b1);
      chk("stream_level", 32'(bus.level), 32'd1);
      chk("stream_data",  32'(bus.rd_data), 32'(pat[k]));
    end
    chk("stream_cnt", 32'(bus.beat_cnt), 32'd3);
    step(1'b0, '0, 1'b1);

    // Fill to full, hold a fifth beat, then free one slot.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, pat[k % 3], 1'b0);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_ready", 32'(bus.ready), 32'd0);
    step(1'b1, pat[1], 1'b0);
    step(1'b1, pat[1], 1'b0);
    chk("held_cnt",   32'(bus.beat_cnt), 32'd4);
    step(1'b1, pat[1], 1'b1);
    chk("pop_level",  32'(bus.level), 32'd3);
    chk("pop_ready",  32'(bus.ready), 32'd1);
    chk("pop_cnt",    32'(bus.beat_cnt), 32'd4);
    step(1'b1, pat[1], 1'b0);
    chk("fifth_cnt",  32'(bus.beat_cnt), 32'd5);
    chk("fifth_full", 32'(bus.full), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("underflow_level", 32'(bus.level), 32'd0);
    chk("underflow_cnt",   32'(bus.beat_cnt), 32'd5);

    // Simultaneous push/pop at level 2 across the pointer wrap.
    step(1'b1, pat[0], 1'b0);
    step(1'b1, pat[1], 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, pat[(k + 2) % 3], 1'b1);
      chk("pp_level", 32'(bus.level), 32'd2);
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Asynchronous reset at level 3, checked before any clock edge.
    for (int k = 0; k < 3; k++) step(1'b1, pat[k], 1'b0);
    chk("pre_rst_level", 32'(bus.level), 32'd3);
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    bus.valid = 1'b0;
    bus.rd_en = 1'b0;
    #1 reset_checks("async");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Stream pattern checks.
    for (int k = 0; k < 4; k++) step(1'b1, pat[k % 3], 1'b1);
    step(1'b0, '0, 1'b1);
    chk("seq_ok", 32'(bus.seq_err), 32'd0);
    step(1'b1, pat[0], 1'b1);
    step(1'b1, pat[1], 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, pat[0], 1'b1);
    step(1'b1, pat[1], 1'b1);
    step(1'b0, '0, 1'b1);
    chk("seq_restart", 32'(bus.seq_err), 32'd0);
`ifdef HS_SLAVE_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    step(1'b1, pat[0], 1'b1);
    step(1'b1, pat[2], 1'b1);
    chk("seq_bad", 32'(bus.seq_err), 32'(exp_err));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("seq_sticky", 32'(bus.seq_err), 32'(exp_err));

    // Randomized traffic; the master holds a stalled beat.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_blocked) begin
        v = bus.valid;
        d = bus.data;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        d = ($urandom_range(0, 3) != 0) ? pat[m_idx] : DW'($urandom_range(0, 7));
      end
      r = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      step(v, d, r);
    end

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_slave.md
Name: hs_slave

Overview:
- Receiving end of the 3-bit valid/ready bus-handshake link.
- Drives ready back to the sending master, captures each accepted beat into a small synchronous FIFO, and presents buffered beats on a show-ahead read port for downstream logic.
- Also counts accepted beats for debug.

Parameters:
DATA_W, 3, width of bus data and FIFO entries
DEPTH, 4, FIFO entries; must be a power of two, >= 2
CNT_W, 8, width of the accepted-beat counter

Ports:
sys_clk  input  1  system clock; all state updates on the rising edge
sys_rst_n  input  1  asynchronous, active-low reset
valid  input  1  master has a beat on data
data  input  DATA_W  beat payload from master
ready  output  1  slave can accept a beat this cycle
rd_en  input  1  downstream pops the head entry
rd_valid  output  1  head entry present (FIFO not empty)
rd_data  output  DATA_W  head entry (show-ahead)
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  clog2(DEPTH)+1  current entry count
beat_cnt  output  CNT_W  accepted beats since reset
seq_err  output  1  sticky sequence-error flag (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately.
  - Pointers = 0, level = 0, beat_cnt = 0, seq_err = 0.
  - Hence empty = 1, full = 0, ready = 1, rd_valid = 0, rd_data = 0.
- ready = !full, combinational from registered level; it does not depend on valid.
- A push happens when valid && ready at a rising edge. data is written at the write pointer, the pointer advances mod DEPTH, and beat_cnt increments (wraps at 2^CNT_W).
- When full, the master must hold valid/data. A pop in the same cycle does not create room until the next cycle (no full-state pass-through).
- A pop happens when rd_en && !empty. The read pointer advances mod DEPTH. rd_en while empty is ignored (no underflow, no pointer move).
- rd_data is the entry at the read pointer whenever !empty and 0 when empty.
- Latency: a beat pushed at edge N is visible on rd_data/rd_valid after edge N (zero-wait show-ahead).
- Simultaneous push and pop with the FIFO non-empty and non-full: both pointers advance and level is unchanged.
- Pop and push in the same cycle while empty: only the push takes effect.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- full = (level == DEPTH); empty = (level == 0).
- Deassertion of valid mid-stream has no effect on FIFO contents.
- Reset asserted mid-transfer discards all buffered entries.

Optional Feature:
- Macro HS_SLAVE_SEQ_CHECK_EN.
- Defined:
  - An expected-pattern index (0..2) tracks the master's fixed stream 3'b111, 3'b101, 3'b110, repeating.
  - On each push, data is compared to pattern[index]. A mismatch sets seq_err, which stays set until reset.
  - The index advances on each push, wrapping 2 -> 0.
  - Any cycle with valid = 0 resets the index to 0.
- Undefined: no checker logic; seq_err is tied to 0.

Decomposition:
- Package hs_pkg:
  - DATA_W default.
  - Pattern constants PAT0 = 3'b111, PAT1 = 3'b101, PAT2 = 3'b110.
  - PAT_LEN = 3.
- Sub-module hs_sync_fifo (parameterised DATA_W/DEPTH):
  - Owns storage, pointers, level, full and empty.
  - hs_slave wraps it with the handshake logic, beat counter and checker.

Test Plan:
- Reset then idle: sys_rst_n low 3 cycles -> ready = 1, empty = 1, level = 0, rd_data = 0, beat_cnt = 0.
- Streaming with no backpressure: valid = 1 for 3 beats 111, 101, 110, rd_en = 1 -> rd_data shows 111, 101, 110 in order one cycle after each push, level never exceeds 1, beat_cnt = 3.
- Fill to full: rd_en = 0, push 4 beats -> full = 1 and ready = 0 after the 4th edge. A 5th held beat is not accepted, beat_cnt = 4. Pulse rd_en once -> ready returns 1 next cycle and the 5th beat is accepted.
- Simultaneous push/pop at level 2 -> level stays 2 and both pointers wrap correctly across the DEPTH boundary over 6 cycles. rd_en while empty -> no change.
- Asynchronous reset asserted mid-stream at level 3 -> outputs return to reset values immediately without waiting for a clock edge.
- With HS_SLAVE_SEQ_CHECK_EN defined:
  - Sequence 111, 101, 110, 111 -> seq_err = 0.
  - Sequence 111, 110 -> seq_err = 1 after the 2nd edge and stays 1.
  - valid drop between beats restarts the expected pattern at 111.
